// File: rtl/regfile_param_clr.sv
// Parameterised integer register file: two registered read ports, one write port,
// and a clear sequencer that zeroes every entry after reset or on clear_req.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_param_clr #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]   write_data,
  input  logic              reg_write,
  input  logic              clear_req,
  output logic [XLEN-1:0]   readdata1,
  output logic [XLEN-1:0]   readdata2,
  output logic              busy
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam bit                ZERO_EN  = (ZERO_REG != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_d;
  logic [XLEN-1:0]   rdata1_d, rdata2_d;

  logic [XLEN-1:0]   regs [DEPTH];
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [XLEN-1:0]   arr_wdata;

  logic              wr_ok;
  logic [XLEN-1:0]   rv1, rv2;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_EN && (a == '0);
  endfunction

  assign wr_ok = reg_write && !is_zero_reg(rd);

  // Read value selection; the hardwired-zero check overrides forwarding.
  always_comb begin : read_mux
    rv1 = regs[rs1];
    rv2 = regs[rs2];
`ifdef RF_BYPASS_EN
    if (wr_ok && (rd == rs1)) rv1 = write_data;
    if (wr_ok && (rd == rs2)) rv2 = write_data;
`endif
    if (is_zero_reg(rs1)) rv1 = '0;
    if (is_zero_reg(rs2)) rv2 = '0;
  end

  // Next-state, clear sequencing and registered-output values.
  always_comb begin : fsm_comb
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = 1'b0;
    rdata1_d  = '0;
    rdata2_d  = '0;
    arr_we    = 1'b0;
    arr_waddr = rd;
    arr_wdata = write_data;
    unique case (state_q)
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = clr_ptr_q;
        arr_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_RUN: begin
        arr_we   = wr_ok;
        rdata1_d = rv1;
        rdata2_d = rv2;
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
        busy_d    = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      busy      <= 1'b1;
      readdata1 <= '0;
      readdata2 <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy      <= busy_d;
      readdata1 <= rdata1_d;
      readdata2 <= rdata2_d;
    end
  end

  // Storage array; contents are left untouched on a reset edge.
  always_ff @(posedge clk) begin
    if (reset && arr_we) begin
      regs[arr_waddr] <= arr_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_param_clr.sv
// Self-checking bench for regfile_param_clr: default instance plus a ZERO_REG=0 instance.
// Expectations follow RF_BYPASS_EN when it is defined for the build.
module tb_regfile_param_clr;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   write_data;
  logic              reg_write, clear_req;
  logic [XLEN-1:0]   readdata1, readdata2;
  logic              busy;
  logic [XLEN-1:0]   readdata1_nz, readdata2_nz;
  logic              busy_nz;

  int checks;
  int failures;

  logic [XLEN-1:0] mdl [32];
  logic [XLEN-1:0] exp1_q [$];
  logic [XLEN-1:0] exp2_q [$];

  regfile_param_clr #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .write_data(write_data), .reg_write(reg_write), .clear_req(clear_req),
    .readdata1(readdata1), .readdata2(readdata2), .busy(busy)
  );

  regfile_param_clr #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .write_data(write_data), .reg_write(reg_write), .clear_req(clear_req),
    .readdata1(readdata1_nz), .readdata2(readdata2_nz), .busy(busy_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    int cnt;
    int bad;
    logic [XLEN-1:0] e1, e2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (readdata1 !== '0 || readdata2 !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got rd1=%h rd2=%h busy=%b exp 0 0 1", readdata1, readdata2, busy);
    end
    reset = 1'b1;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (busy !== 1'b1) break;
      cnt++;
      if (readdata1 !== '0 || readdata2 !== '0) bad++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 32) begin
      failures++;
      $display("FAIL reset_busy_len got=%0d exp=32", cnt);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_outputs_zero got nonzero_cycles=%0d exp=0", bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_drop got=%b exp=0", busy);
    end
    rs1 = 5'd7;
    rs2 = 5'd7;
    exp1_q.push_back(mdl[7]);
    exp2_q.push_back(mdl[7]);
    @(negedge clk);
    e1 = exp1_q.pop_front();
    e2 = exp2_q.pop_front();
    checks++;
    if (readdata1 !== e1 || readdata2 !== e2) begin
      failures++;
      $display("FAIL read_r7_after_clear got=%h/%h exp=%h/%h", readdata1, readdata2, e1, e2);
    end
  endtask

  task automatic test_write_read();
    logic [XLEN-1:0] e1, e2;
    rd = 5'd5; write_data = 64'h1234; reg_write = 1'b1;
    mdl[5] = 64'h1234;
    @(negedge clk);
    rd = 5'd10; write_data = 64'hA5A5_0000_DEAD_BEEF;
    mdl[10] = 64'hA5A5_0000_DEAD_BEEF;
    rs1 = 5'd5; rs2 = 5'd5;
    exp1_q.push_back(mdl[5]);
    exp2_q.push_back(mdl[5]);
    @(negedge clk);
    reg_write = 1'b0;
    e1 = exp1_q.pop_front();
    e2 = exp2_q.pop_front();
    checks++;
    if (readdata1 !== e1 || readdata2 !== e2) begin
      failures++;
      $display("FAIL write_read_r5 got=%h/%h exp=%h/%h", readdata1, readdata2, e1, e2);
    end
    rs1 = 5'd10; rs2 = 5'd5;
    exp1_q.push_back(mdl[10]);
    exp2_q.push_back(mdl[5]);
    @(negedge clk);
    e1 = exp1_q.pop_front();
    e2 = exp2_q.pop_front();
    checks++;
    if (readdata1 !== e1 || readdata2 !== e2) begin
      failures++;
      $display("FAIL write_read_r10_r5 got=%h/%h exp=%h/%h", readdata1, readdata2, e1, e2);
    end
  endtask

  task automatic test_zero_reg();
    logic [XLEN-1:0] nz0;
    logic [XLEN-1:0] nz_exp;
    rd = 5'd0; write_data = 64'hFFFF; reg_write = 1'b1;
    nz0 = 64'hFFFF;
    @(negedge clk);
    reg_write = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    checks++;
    if (readdata1 !== '0 || readdata2 !== '0) begin
      failures++;
      $display("FAIL zero_reg_read got=%h/%h exp=0/0", readdata1, readdata2);
    end
    checks++;
    if (readdata1_nz !== nz0 || readdata2_nz !== nz0) begin
      failures++;
      $display("FAIL nonzero_r0_read got=%h/%h exp=%h", readdata1_nz, readdata2_nz, nz0);
    end
    rd = 5'd0; write_data = 64'h1111; reg_write = 1'b1;
`ifdef RF_BYPASS_EN
    nz_exp = 64'h1111;
`else
    nz_exp = nz0;
`endif
    @(negedge clk);
    reg_write = 1'b0;
    checks++;
    if (readdata1 !== '0) begin
      failures++;
      $display("FAIL zero_reg_same_cycle got=%h exp=0", readdata1);
    end
    checks++;
    if (readdata1_nz !== nz_exp) begin
      failures++;
      $display("FAIL nonzero_r0_same_cycle got=%h exp=%h", readdata1_nz, nz_exp);
    end
  endtask

  task automatic test_forwarding();
    logic [XLEN-1:0] e1, e2;
    rd = 5'd9; write_data = 64'h55; reg_write = 1'b1;
    mdl[9] = 64'h55;
    @(negedge clk);
    rd = 5'd9; write_data = 64'hAA; reg_write = 1'b1;
    rs1 = 5'd9; rs2 = 5'd5;
`ifdef RF_BYPASS_EN
    exp1_q.push_back(64'hAA);
`else
    exp1_q.push_back(mdl[9]);
`endif
    exp2_q.push_back(mdl[5]);
    mdl[9] = 64'hAA;
    @(negedge clk);
    reg_write = 1'b0;
    e1 = exp1_q.pop_front();
    e2 = exp2_q.pop_front();
    checks++;
    if (readdata1 !== e1 || readdata2 !== e2) begin
      failures++;
      $display("FAIL same_cycle_rw_r9 got=%h/%h exp=%h/%h", readdata1, readdata2, e1, e2);
    end
    rs1 = 5'd9; rs2 = 5'd9;
    exp1_q.push_back(mdl[9]);
    exp2_q.push_back(mdl[9]);
    @(negedge clk);
    e1 = exp1_q.pop_front();
    e2 = exp2_q.pop_front();
    checks++;
    if (readdata1 !== e1 || readdata2 !== e2) begin
      failures++;
      $display("FAIL next_read_r9 got=%h/%h exp=%h/%h", readdata1, readdata2, e1, e2);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] e1, e2;
    int bad;
    for (int i = 1; i < 32; i++) begin
      rd = ADDR_W'(i); write_data = XLEN'(i); reg_write = 1'b1;
      mdl[i] = XLEN'(i);
      @(negedge clk);
    end
    reg_write = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rs1 = ADDR_W'(i);
      rs2 = ADDR_W'(31 - i);
      exp1_q.push_back(mdl[i]);
      exp2_q.push_back(mdl[31 - i]);
      @(negedge clk);
      e1 = exp1_q.pop_front();
      e2 = exp2_q.pop_front();
      checks++;
      if (readdata1 !== e1 || readdata2 !== e2) begin
        failures++;
        bad++;
        if (bad < 4) $display("FAIL b2b_read_%0d got=%h/%h exp=%h/%h", i, readdata1, readdata2, e1, e2);
      end
    end
  endtask

  task automatic test_clear();
    int cnt;
    int bad;
    logic [XLEN-1:0] e1, e2;
    rs1 = 5'd0; rs2 = 5'd0;
    rd = 5'd3; write_data = 64'h99; reg_write = 1'b1; clear_req = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; clear_req = 1'b0;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (busy !== 1'b1) break;
      cnt++;
      if (readdata1 !== '0 || readdata2 !== '0) bad++;
      if (i == 4) begin
        rd = 5'd3; write_data = 64'h77; reg_write = 1'b1; clear_req = 1'b1;
        rs1 = 5'd31; rs2 = 5'd3;
      end else if (i == 5) begin
        reg_write = 1'b0; clear_req = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    checks++;
    if (cnt != 32) begin
      failures++;
      $display("FAIL clear_busy_len got=%0d exp=32", cnt);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clear_outputs_zero got nonzero_cycles=%0d exp=0", bad);
    end
    rs1 = 5'd3; rs2 = 5'd31;
    exp1_q.push_back(mdl[3]);
    exp2_q.push_back(mdl[31]);
    @(negedge clk);
    e1 = exp1_q.pop_front();
    e2 = exp2_q.pop_front();
    checks++;
    if (readdata1 !== e1 || readdata2 !== e2) begin
      failures++;
      $display("FAIL after_clear_r3_r31 got=%h/%h exp=%h/%h", readdata1, readdata2, e1, e2);
    end
  endtask

  task automatic test_reset_restart();
    int cnt;
    logic [XLEN-1:0] e1, e2;
    rd = 5'd8; write_data = 64'h88; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
    rs1 = 5'd8; rs2 = 5'd8;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (readdata1 !== '0 || readdata2 !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_run got rd1=%h rd2=%h busy=%b exp 0 0 1", readdata1, readdata2, busy);
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (busy !== 1'b1) break;
      cnt++;
      if (i == 30) begin
        rd = 5'd6; write_data = 64'h66; reg_write = 1'b1;
      end else if (i == 31) begin
        rd = 5'd8; write_data = 64'h67; reg_write = 1'b1;
      end else begin
        reg_write = 1'b0;
      end
      @(negedge clk);
    end
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    checks++;
    if (cnt != 32) begin
      failures++;
      $display("FAIL restart_busy_len got=%0d exp=32", cnt);
    end
    rs1 = 5'd6; rs2 = 5'd8;
    exp1_q.push_back(mdl[6]);
    exp2_q.push_back(mdl[8]);
    @(negedge clk);
    e1 = exp1_q.pop_front();
    e2 = exp2_q.pop_front();
    checks++;
    if (readdata1 !== e1 || readdata2 !== e2) begin
      failures++;
      $display("FAIL restart_no_early_write got=%h/%h exp=%h/%h", readdata1, readdata2, e1, e2);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    reset = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0;
    write_data = '0; reg_write = 1'b0; clear_req = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_forwarding();
    test_back_to_back();
    test_clear();
    test_reset_restart();
    checks++;
    if (exp1_q.size() != 0 || exp2_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp1_q.size(), exp2_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
